// File: rtl/qsm_dim_master.sv
// QSM DIM line master: reset, trigger and serial readout of daisy-chained DIMs.
// Optional feedback-line check is built when QSM_FB_CHECK_EN is defined.
`timescale 1ns/1ps
module qsm_dim_master #(
    parameter int CLK_DIV    = 4,
    parameter int CLK_PER_US = 100,
    parameter int RST_CYCLES = 1000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        ctrl_reset_i,
    input  logic        ctrl_trig_i,
    input  logic [3:0]  ctrl_last_reg_adr_i,
    input  logic [3:0]  ctrl_max_dim_no_i,
    input  logic [9:0]  ctrl_read_delay_i,
    output logic        stat_busy_o,
    output logic        stat_done_o,
    output logic        stat_err_many_o,
    output logic        stat_err_fb_o,
    output logic [3:0]  stat_dim_count_o,
    output logic        dim_rst_o,
    output logic        dim_trig_o,
    output logic        dim_sck_o,
    output logic [3:0]  dim_adr_o,
    input  logic        dim_sdi_i,
    input  logic        dim_fb_i,
    output logic        mem_we_o,
    output logic [6:0]  mem_addr_o,
    output logic [15:0] mem_data_o
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE, RESET, TRIG, SHIFT, STORE, DELAY
    } state_t;

    state_t        state, state_next;
    logic [31:0]   cnt;
    logic [DW-1:0] div_cnt;
    logic          sck;
    logic [4:0]    bit_cnt;
    logic [3:0]    slot, reg_idx, last_reg, max_dim, dim_count;
    logic [9:0]    delay_us;
    logic [15:0]   shreg;
    logic [7:0]    wcnt;
    logic          done, err_many;
    logic [31:0]   delay_cycles;
    logic          sample, pass_end, word_end, last_pass;

    assign delay_cycles = 32'(delay_us) * 32'(CLK_PER_US);
    assign sample    = (state == SHIFT) && sck && (div_cnt == DIV_LAST);
    assign pass_end  = sample && (bit_cnt == 5'd0) &&
                       (!dim_sdi_i || (slot == max_dim));
    assign word_end  = sample && (bit_cnt == 5'd16);
    assign last_pass = (reg_idx == last_reg);

    assign stat_done_o      = done;
    assign stat_err_many_o  = err_many;
    assign stat_dim_count_o = dim_count;
    assign dim_sck_o        = sck;
    assign dim_adr_o        = reg_idx;
    assign mem_addr_o       = wcnt[6:0];
    assign mem_data_o       = shreg;

`ifdef QSM_FB_CHECK_EN
    logic err_fb;
    assign stat_err_fb_o = err_fb;
`else
    logic unused_fb;
    assign unused_fb     = dim_fb_i;
    assign stat_err_fb_o = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state decode and state-derived line/memory strobes
    always_comb begin
        state_next  = state;
        stat_busy_o = (state != IDLE);
        dim_rst_o   = (state == RESET);
        dim_trig_o  = (state == TRIG);
        mem_we_o    = (state == STORE) && !wcnt[7];
        if (ctrl_reset_i) begin
            state_next = RESET;
        end else begin
            unique case (state)
                IDLE:  if (ctrl_trig_i) state_next = TRIG;
                RESET: if (cnt == 32'd1) state_next = IDLE;
                TRIG:  state_next = SHIFT;
                SHIFT: begin
                    if (word_end)
                        state_next = STORE;
                    else if (pass_end) begin
                        if (last_pass)
                            state_next = IDLE;
                        else if (delay_cycles == 32'd0)
                            state_next = SHIFT;
                        else
                            state_next = DELAY;
                    end
                end
                STORE: state_next = SHIFT;
                DELAY: if (cnt == 32'd1) state_next = SHIFT;
                default: state_next = IDLE;
            endcase
        end
    end

    // Datapath: timers, sck generation, shifting, word counter and flags
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt       <= '0;
            div_cnt   <= '0;
            sck       <= 1'b0;
            bit_cnt   <= '0;
            slot      <= '0;
            reg_idx   <= '0;
            last_reg  <= '0;
            max_dim   <= '0;
            delay_us  <= '0;
            shreg     <= '0;
            wcnt      <= '0;
            done      <= 1'b0;
            err_many  <= 1'b0;
            dim_count <= '0;
`ifdef QSM_FB_CHECK_EN
            err_fb    <= 1'b0;
`endif
        end else if (ctrl_reset_i) begin
            cnt       <= 32'(RST_CYCLES);
            div_cnt   <= '0;
            sck       <= 1'b0;
            done      <= 1'b0;
            err_many  <= 1'b0;
            dim_count <= '0;
`ifdef QSM_FB_CHECK_EN
            err_fb    <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (ctrl_trig_i) begin
                        last_reg <= ctrl_last_reg_adr_i;
                        max_dim  <= ctrl_max_dim_no_i;
                        delay_us <= ctrl_read_delay_i;
                    end
                end
                RESET: cnt <= cnt - 32'd1;
                TRIG: begin
                    done      <= 1'b0;
                    err_many  <= 1'b0;
                    dim_count <= '0;
`ifdef QSM_FB_CHECK_EN
                    err_fb    <= 1'b0;
`endif
                    wcnt      <= '0;
                    reg_idx   <= '0;
                    slot      <= '0;
                    bit_cnt   <= '0;
                    div_cnt   <= '0;
                    sck       <= 1'b0;
                end
                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        sck     <= ~sck;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                    if (sample) begin
`ifdef QSM_FB_CHECK_EN
                        if (!dim_fb_i) err_fb <= 1'b1;
`endif
                        if (bit_cnt == 5'd0) begin
                            if (!dim_sdi_i) begin
                                if (reg_idx == 4'd0) dim_count <= slot;
                            end else if (slot == max_dim) begin
                                err_many <= 1'b1;
                            end else begin
                                bit_cnt <= 5'd1;
                            end
                        end else begin
                            shreg   <= {shreg[14:0], dim_sdi_i};
                            bit_cnt <= word_end ? 5'd0 : bit_cnt + 5'd1;
                        end
                        if (pass_end) begin
                            slot <= '0;
                            if (last_pass)
                                done <= 1'b1;
                            else if (delay_cycles == 32'd0)
                                reg_idx <= reg_idx + 4'd1;
                            else
                                cnt <= delay_cycles;
                        end
                    end
                end
                STORE: begin
                    if (!wcnt[7]) wcnt <= wcnt + 8'd1;
                    slot <= slot + 4'd1;
                end
                DELAY: begin
                    cnt <= cnt - 32'd1;
                    if (cnt == 32'd1) reg_idx <= reg_idx + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
